// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 16-bit 5-stage pipeline: load-use bubbles, redirect
// flushes, multi-cycle data-memory waits, IN-port handshake and a stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter int n       = 16,
   parameter int MEM_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   ID_rs,
   input  logic [2:0]   ID_rt,
   input  logic         ID_use_rs,
   input  logic         ID_use_rt,
   input  logic         EXE_MemRead,
   input  logic [2:0]   EXE_WriteRegister,
   input  logic         EXE_redirect,
   input  logic         MEM_MemRead,
   input  logic         MEM_MemWrite,
   input  logic         MEM_IN,
   input  logic         in_valid,
   output logic         in_ack,
   output logic         pc_en,
   output logic         ifid_en,
   output logic         ifid_flush,
   output logic         idexe_en,
   output logic         idexe_flush,
   output logic         exemem_en,
   output logic         memwb_en,
   output logic [n-1:0] stall_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      IN_WAIT  = 2'd2
   } state_t;

   typedef struct packed {
      logic in_ack;
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idexe_en;
      logic idexe_flush;
      logic exemem_en;
      logic memwb_en;
   } ctrl_t;

   // First-cycle freeze already covers one extra cycle, so the counter starts at MEM_LAT-2.
   localparam bit         MULTI_CYCLE = (MEM_LAT > 1);
   localparam logic [3:0] WAIT_INIT   = MULTI_CYCLE ? 4'(MEM_LAT - 2) : 4'd0;

   state_t     state, state_nxt;
   logic [3:0] wait_cnt, wait_nxt;
   ctrl_t      ctrl;

   logic load_use;
   logic mem_access;
   logic in_starved;

   assign load_use = EXE_MemRead &
                     ((ID_use_rs & (EXE_WriteRegister == ID_rs)) |
                      (ID_use_rt & (EXE_WriteRegister == ID_rt)));
   assign mem_access = MEM_MemRead | MEM_MemWrite;
   assign in_starved = MEM_IN & ~in_valid;

   // A redirect discards both younger instructions, which makes any load-use bubble moot.
   function automatic ctrl_t advance(input logic redirect, input logic lu, input logic ack);
      ctrl_t c;
      c             = '1;
      c.ifid_flush  = 1'b0;
      c.idexe_flush = 1'b0;
      c.in_ack      = ack;
      if (redirect) begin
         c.ifid_flush  = 1'b1;
         c.idexe_flush = 1'b1;
      end else if (lu) begin
         c.pc_en       = 1'b0;
         c.ifid_en     = 1'b0;
         c.idexe_flush = 1'b1;
      end
      return c;
   endfunction

   // NOTE: every signal driven here gets a default first, so no path leaves one
   // unassigned and no latch is inferred; the freeze case is simply the default.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      ctrl      = '0;
      if (rst) begin
         unique case (state)
            RUN: begin
               if (mem_access && MULTI_CYCLE) begin
                  wait_nxt  = WAIT_INIT;
                  state_nxt = MEM_WAIT;
               end else if (in_starved) begin
                  state_nxt = IN_WAIT;
               end else begin
                  ctrl = advance(EXE_redirect, load_use, MEM_IN & in_valid);
               end
            end
            MEM_WAIT: begin
               if (wait_cnt != 4'd0) begin
                  wait_nxt = wait_cnt - 4'd1;
               end else if (in_starved) begin
                  state_nxt = IN_WAIT;
               end else begin
                  ctrl      = advance(EXE_redirect, load_use, MEM_IN & in_valid);
                  state_nxt = RUN;
               end
            end
            IN_WAIT: begin
               if (in_valid) begin
                  ctrl      = advance(EXE_redirect, load_use, 1'b1);
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RUN;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count <= '0;
      end else if (!ctrl.pc_en && (stall_count != '1)) begin
         stall_count <= stall_count + n'(1);
      end
   end

   assign in_ack      = ctrl.in_ack;
   assign pc_en       = ctrl.pc_en;
   assign ifid_en     = ctrl.ifid_en;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idexe_en    = ctrl.idexe_en;
   assign idexe_flush = ctrl.idexe_flush;
   assign exemem_en   = ctrl.exemem_en;
   assign memwb_en    = ctrl.memwb_en;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a RUN-state vector table on a MEM_LAT=1 instance,
// plus hand sequences for memory waits, IN handshake and mid-wait reset (MEM_LAT=3/4).
module tb_pipe_hazard_ctrl;

   localparam int N = 16;

   // Output packing: {in_ack, pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush, exemem_en, memwb_en}
   localparam logic [7:0] FRZ = 8'b0000_0000;
   localparam logic [7:0] ADV = 8'b0110_1011;
   localparam logic [7:0] LU  = 8'b0000_1111;
   localparam logic [7:0] RED = 8'b0111_1111;
   localparam logic [7:0] ACK = 8'b1110_1011;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] id_rs, id_rt, exe_wr;
   logic       use_rs, use_rt, exe_rd, redir, mem_rd, mem_wr, mem_in, in_valid;

   logic [7:0]   o1, o3, o4;
   logic [N-1:0] sc1, sc3, sc4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.n(N), .MEM_LAT(1)) u1 (
      .clk(clk), .rst(rst), .ID_rs(id_rs), .ID_rt(id_rt), .ID_use_rs(use_rs), .ID_use_rt(use_rt),
      .EXE_MemRead(exe_rd), .EXE_WriteRegister(exe_wr), .EXE_redirect(redir),
      .MEM_MemRead(mem_rd), .MEM_MemWrite(mem_wr), .MEM_IN(mem_in), .in_valid(in_valid),
      .in_ack(o1[7]), .pc_en(o1[6]), .ifid_en(o1[5]), .ifid_flush(o1[4]), .idexe_en(o1[3]),
      .idexe_flush(o1[2]), .exemem_en(o1[1]), .memwb_en(o1[0]), .stall_count(sc1));

   pipe_hazard_ctrl #(.n(N), .MEM_LAT(3)) u3 (
      .clk(clk), .rst(rst), .ID_rs(id_rs), .ID_rt(id_rt), .ID_use_rs(use_rs), .ID_use_rt(use_rt),
      .EXE_MemRead(exe_rd), .EXE_WriteRegister(exe_wr), .EXE_redirect(redir),
      .MEM_MemRead(mem_rd), .MEM_MemWrite(mem_wr), .MEM_IN(mem_in), .in_valid(in_valid),
      .in_ack(o3[7]), .pc_en(o3[6]), .ifid_en(o3[5]), .ifid_flush(o3[4]), .idexe_en(o3[3]),
      .idexe_flush(o3[2]), .exemem_en(o3[1]), .memwb_en(o3[0]), .stall_count(sc3));

   pipe_hazard_ctrl #(.n(N), .MEM_LAT(4)) u4 (
      .clk(clk), .rst(rst), .ID_rs(id_rs), .ID_rt(id_rt), .ID_use_rs(use_rs), .ID_use_rt(use_rt),
      .EXE_MemRead(exe_rd), .EXE_WriteRegister(exe_wr), .EXE_redirect(redir),
      .MEM_MemRead(mem_rd), .MEM_MemWrite(mem_wr), .MEM_IN(mem_in), .in_valid(in_valid),
      .in_ack(o4[7]), .pc_en(o4[6]), .ifid_en(o4[5]), .ifid_flush(o4[4]), .idexe_en(o4[3]),
      .idexe_flush(o4[2]), .exemem_en(o4[1]), .memwb_en(o4[0]), .stall_count(sc4));

   typedef struct {
      logic [2:0] rs, rt, wr;
      logic       use_rs, use_rt, exe_rd, redir, mem_rd, mem_wr, mem_in, in_valid;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      id_rs = 3'd0; id_rt = 3'd0; exe_wr = 3'd0;
      use_rs = 1'b0; use_rt = 1'b0; exe_rd = 1'b0; redir = 1'b0;
      mem_rd = 1'b0; mem_wr = 1'b0; mem_in = 1'b0; in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic vec_t mk(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] wr,
                               input logic [7:0] flags, input logic [7:0] exp);
      vec_t v;
      v.rs = rs; v.rt = rt; v.wr = wr;
      {v.use_rs, v.use_rt, v.exe_rd, v.redir, v.mem_rd, v.mem_wr, v.mem_in, v.in_valid} = flags;
      v.exp = exp;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_sc;
      // flags: {use_rs, use_rt, exe_rd, redir, mem_rd, mem_wr, mem_in, in_valid}
      vecs[0]  = mk(3'd0, 3'd0, 3'd0, 8'b0000_0000, ADV);
      vecs[1]  = mk(3'd3, 3'd0, 3'd3, 8'b1010_0000, LU);
      vecs[2]  = mk(3'd3, 3'd0, 3'd3, 8'b0010_0000, ADV);
      vecs[3]  = mk(3'd1, 3'd5, 3'd5, 8'b0110_0000, LU);
      vecs[4]  = mk(3'd3, 3'd0, 3'd3, 8'b1000_0000, ADV);
      vecs[5]  = mk(3'd3, 3'd0, 3'd2, 8'b1010_0000, ADV);
      vecs[6]  = mk(3'd3, 3'd0, 3'd3, 8'b1011_0000, RED);
      vecs[7]  = mk(3'd0, 3'd0, 3'd0, 8'b0001_0000, RED);
      vecs[8]  = mk(3'd0, 3'd0, 3'd0, 8'b0000_1000, ADV);
      vecs[9]  = mk(3'd4, 3'd0, 3'd4, 8'b1010_0100, LU);
      vecs[10] = mk(3'd0, 3'd0, 3'd0, 8'b0000_0011, ACK);
      vecs[11] = mk(3'd0, 3'd0, 3'd0, 8'b0000_0001, ADV);
      vecs[12] = mk(3'd0, 3'd0, 3'd0, 8'b0001_0011, 8'b1111_1111);

      clear_inputs();
      rst = 1'b0;
      #12;
      check("reset_outputs", {24'd0, o1}, {24'd0, FRZ});
      check("reset_stall_count", {16'd0, sc1}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // RUN-state combinational rules on the single-cycle-memory instance
      exp_sc = 0;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         id_rs = vecs[i].rs; id_rt = vecs[i].rt; exe_wr = vecs[i].wr;
         use_rs = vecs[i].use_rs; use_rt = vecs[i].use_rt; exe_rd = vecs[i].exe_rd;
         redir = vecs[i].redir; mem_rd = vecs[i].mem_rd; mem_wr = vecs[i].mem_wr;
         mem_in = vecs[i].mem_in; in_valid = vecs[i].in_valid;
         #1;
         check($sformatf("vec%0d_ctrl", i), {24'd0, o1}, {24'd0, vecs[i].exp});
         if (!vecs[i].exp[6]) exp_sc++;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_stall_count", i), {16'd0, sc1}, exp_sc);
      end

      // MEM_LAT=4 load: three frozen cycles then release; MEM_LAT=3 sees two
      do_reset();
      mem_rd = 1'b1;
      #1;
      check("lat4_c1_freeze", {24'd0, o4}, {24'd0, FRZ});
      check("lat1_load_no_stall", {24'd0, o1}, {24'd0, ADV});
      @(negedge clk);
      mem_rd = 1'b0;
      #1;
      check("lat4_c2_freeze", {24'd0, o4}, {24'd0, FRZ});
      @(negedge clk);
      #1;
      check("lat4_c3_freeze", {24'd0, o4}, {24'd0, FRZ});
      @(negedge clk);
      #1;
      check("lat4_c4_release", {24'd0, o4}, {24'd0, ADV});
      @(negedge clk);
      #1;
      check("lat4_back_in_run", {24'd0, o4}, {24'd0, ADV});
      check("lat4_stall_count", {16'd0, sc4}, 32'd3);
      check("lat3_stall_count", {16'd0, sc3}, 32'd2);
      check("lat1_stall_count", {16'd0, sc1}, 32'd0);

      // IN handshake: five starved cycles, then a one-cycle ack
      do_reset();
      mem_in = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("in_wait_c%0d", c), {24'd0, o1}, {24'd0, FRZ});
         @(negedge clk);
      end
      in_valid = 1'b1;
      #1;
      check("in_accept", {24'd0, o1}, {24'd0, ACK});
      @(negedge clk);
      mem_in = 1'b0;
      in_valid = 1'b0;
      #1;
      check("in_ack_one_cycle", {24'd0, o1}, {24'd0, ADV});
      check("in_stall_count", {16'd0, sc1}, 32'd5);

      // MEM_LAT=3 store with redirect held: flushes only on the release cycle
      do_reset();
      mem_wr = 1'b1;
      redir = 1'b1;
      #1;
      check("st_redir_c1", {24'd0, o3}, {24'd0, FRZ});
      @(negedge clk);
      #1;
      check("st_redir_c2", {24'd0, o3}, {24'd0, FRZ});
      @(negedge clk);
      #1;
      check("st_redir_release", {24'd0, o3}, {24'd0, RED});
      @(negedge clk);
      clear_inputs();

      // Reset asserted mid-wait (MEM_LAT=4, wait_cnt=1), between clock edges
      do_reset();
      mem_rd = 1'b1;
      @(negedge clk);
      mem_rd = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midwait_rst_outputs", {24'd0, o4}, {24'd0, FRZ});
      check("midwait_rst_stall_count", {16'd0, sc4}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_rst_first_cycle", {24'd0, o4}, {24'd0, ADV});
      @(negedge clk);
      #1;
      check("post_rst_second_cycle", {24'd0, o4}, {24'd0, ADV});
      check("post_rst_stall_count", {16'd0, sc4}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
